// File: rtl/video_frame_tracker.sv
// Video frame position tracker for an AXI-stream style pixel interface.
// Tracks the column/line the next accepted beat will occupy and generates
// tuser/tlast markers. It also counts completed frames and flags resyncs
// that arrive before a frame has finished.
module video_frame_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 12,
  parameter int FW       = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          tvalid,
  input  logic          tready,
  input  logic          sync,
  input  logic          clear_err,
  output logic [CW-1:0] x_pos,
  output logic [CW-1:0] y_pos,
  output logic          tuser,
  output logic          tlast,
  output logic          frame_done,
  output logic [FW-1:0] frame_cnt,
  output logic          short_frame
);

  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(V_ACTIVE - 1);

  logic [CW-1:0] x_pos_q, x_pos_d;
  logic [CW-1:0] y_pos_q, y_pos_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          short_frame_q, short_frame_d;

  logic acc;
  logic at_origin;
  logic at_line_end;
  logic at_frame_end;

  assign acc          = enable & tvalid & tready;
  assign at_origin    = (x_pos_q == '0) && (y_pos_q == '0);
  assign at_line_end  = (x_pos_q == X_LAST);
  assign at_frame_end = at_line_end && (y_pos_q == Y_LAST);

  // Next-state: sync overrides normal advance; a beat taken with sync
  // becomes pixel (0,0) of the new frame, so the position lands on (1,0).
  always_comb begin
    x_pos_d       = x_pos_q;
    y_pos_d       = y_pos_q;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = 1'b0;
    short_frame_d = short_frame_q;

    if (sync) begin
      x_pos_d = acc ? CW'(1) : '0;
      y_pos_d = '0;
    end else if (acc) begin
      if (at_line_end) begin
        x_pos_d = '0;
        if (at_frame_end) begin
          y_pos_d      = '0;
          frame_cnt_d  = frame_cnt_q + 1'b1;
          frame_done_d = 1'b1;
        end else begin
          y_pos_d = y_pos_q + 1'b1;
        end
      end else begin
        x_pos_d = x_pos_q + 1'b1;
      end
    end

    // Setting the error wins over clearing it in the same cycle.
    if (sync && !at_origin) begin
      short_frame_d = 1'b1;
    end else if (clear_err) begin
      short_frame_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset to pixel (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_pos_q       <= '0;
      y_pos_q       <= '0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign x_pos       = x_pos_q;
  assign y_pos       = y_pos_q;
  assign frame_cnt   = frame_cnt_q;
  assign frame_done  = frame_done_q;
  assign short_frame = short_frame_q;
  assign tuser       = tvalid & at_origin;
  assign tlast       = tvalid & at_line_end;

endmodule

// File: doc/video_frame_tracker.md
VIDEO_FRAME_TRACKER -- requirements
Module: video_frame_tracker

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line (SHALL be >= 2).
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame (SHALL be >= 2).
REQ-003 Parameter CW, default 12, width of x/y position counters (SHALL satisfy 2^CW >= max(H_ACTIVE, V_ACTIVE)).
REQ-004 Parameter FW, default 16, width of frame counter.
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  counting enable; 0 = counters hold.
REQ-008 tvalid  input  1  upstream pixel valid.
REQ-009 tready  input  1  downstream ready; beat accepted when tvalid & tready.
REQ-010 sync  input  1  single-cycle frame resync pulse (external vsync edge).
REQ-011 clear_err  input  1  clears sticky error flag.
REQ-012 x_pos  output  CW  column of the current beat.
REQ-013 y_pos  output  CW  line of the current beat.
REQ-014 tuser  output  1  start-of-frame marker for the current beat.
REQ-015 tlast  output  1  end-of-line marker for the current beat.
REQ-016 frame_done  output  1  registered one-cycle pulse after last pixel of a frame accepted.
REQ-017 frame_cnt  output  FW  completed-frame count.
REQ-018 short_frame  output  1  sticky error: resync arrived mid-frame.

Function
REQ-019 Beat acceptance ("acc") SHALL be enable & tvalid & tready; no counter, flag or pulse SHALL change on a cycle without acc, except sync/clear_err/frame_done deassertion as stated below.
REQ-020 x_pos/y_pos SHALL be registered state giving the position the next accepted beat will occupy.
REQ-021 tuser SHALL equal tvalid & (x_pos==0) & (y_pos==0), combinational from registers, zero-latency with the beat.
REQ-022 tlast SHALL equal tvalid & (x_pos==H_ACTIVE-1), combinational, zero-latency.
REQ-023 On acc with x_pos<H_ACTIVE-1: x_pos increments by 1, y_pos unchanged.
REQ-024 On acc with x_pos==H_ACTIVE-1 and y_pos<V_ACTIVE-1: x_pos wraps to 0, y_pos increments.
REQ-025 On acc with x_pos==H_ACTIVE-1 and y_pos==V_ACTIVE-1: both wrap to 0, frame_cnt increments modulo 2^FW, frame_done is 1 in the following cycle.
REQ-026 frame_done SHALL be high for exactly one cycle per completed frame, regardless of tvalid/tready in that cycle.
REQ-027 sync high SHALL force x_pos=0, y_pos=0 on the next edge; frame_cnt SHALL NOT increment and frame_done SHALL NOT pulse on sync.
REQ-028 sync with acc in the same cycle: the beat SHALL be taken as pixel (0,0) of the new frame; next state x_pos=1, y_pos=0; tuser for that beat reflects pre-sync registers.
REQ-029 sync while (x_pos,y_pos) != (0,0) SHALL set short_frame on the next edge; sync at (0,0) SHALL NOT set it.
REQ-030 short_frame SHALL remain set until clear_err; simultaneous set and clear_err SHALL leave it set.
REQ-031 sync SHALL take effect even when enable=0.
REQ-032 Backpressure (tvalid=1, tready=0) SHALL hold all counters, and tuser/tlast SHALL remain stable for the held beat.

Reset
REQ-033 resetn low SHALL asynchronously set x_pos=0, y_pos=0, frame_cnt=0, frame_done=0, short_frame=0.
REQ-034 While in reset, tuser and tlast SHALL follow tvalid (position (0,0): tuser=tvalid, tlast=0).
REQ-035 Reset deassertion mid-frame SHALL restart at pixel (0,0) without setting short_frame.

Verification
REQ-036 H_ACTIVE=4, V_ACTIVE=3, continuous acc for 12 beats -> tuser on beat 0 only, tlast on beats 3,7,11, frame_done one cycle after beat 11, frame_cnt=1.
REQ-037 Same config, tready toggled 1/0 each cycle for 24 cycles -> 12 beats accepted, identical tuser/tlast sequence, counters frozen on tready=0 cycles.
REQ-038 sync pulse after 5 accepted beats -> next state (0,0), short_frame=1, frame_cnt unchanged; clear_err -> short_frame=0.
REQ-039 sync and acc in same cycle at position (2,1) -> next x_pos=1, y_pos=0, short_frame=1.
REQ-040 FW=2, run 5 full frames -> frame_cnt sequence 1,2,3,0,1, five frame_done pulses.
REQ-041 resetn pulsed low at position (3,2) -> immediate (0,0), frame_cnt=0, short_frame=0; enable=0 with tvalid=tready=1 -> no counter change.
